// File: rtl/dec_stage.sv
// dec_stage: instruction register, 32x32 register file with write-to-read bypass and immediate extender
module dec_stage #(
  parameter int DATA_W = 32,
  parameter logic [31:0] NOP_WORD = 32'h0,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [31:0]       Instr,
  input  logic              IR_LdEn,
  input  logic              Flush,
  input  logic              RF_B_sel,
  input  logic [1:0]        ImmExt,
  input  logic              RF_WrEn,
  input  logic [4:0]        RF_WrAddr,
  input  logic              RF_WrData_sel,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic [DATA_W-1:0] MEM_out,
  output logic [31:0]       IR_out,
  output logic              Valid,
  output logic [DATA_W-1:0] RF_A,
  output logic [DATA_W-1:0] RF_B,
  output logic [DATA_W-1:0] Immed
);
  logic [DATA_W-1:0] rf [32];
  logic [DATA_W-1:0] wd, sx;
  logic [4:0] ra, rb;
  logic [15:0] imm;
  logic we;
  assign wd = RF_WrData_sel ? MEM_out : ALU_out;
  assign we = Reset && RF_WrEn && (RF_WrAddr != 5'd0);
  assign ra = IR_out[25:21];
  assign rb = RF_B_sel ? IR_out[20:16] : IR_out[15:11];
  assign imm = IR_out[15:0];
  assign sx = {{(DATA_W-16){imm[15]}}, imm};
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      IR_out <= NOP_WORD;
      Valid <= 1'b0;
    end else if (Flush) begin
      IR_out <= NOP_WORD;
      Valid <= 1'b0;
    end else if (IR_LdEn) begin
      IR_out <= Instr;
      Valid <= 1'b1;
    end
  end
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (we) begin
      rf[RF_WrAddr] <= wd;
    end
  end
  always_comb begin
    RF_A = (ra == 5'd0) ? '0 : (BYPASS && we && RF_WrAddr == ra) ? wd : rf[ra];
    RF_B = (rb == 5'd0) ? '0 : (BYPASS && we && RF_WrAddr == rb) ? wd : rf[rb];
    Immed = (ImmExt == 2'd0) ? DATA_W'(imm) :
            (ImmExt == 2'd1) ? sx :
            (ImmExt == 2'd2) ? {sx[DATA_W-3:0], 2'b00} :
                               DATA_W'({imm, 16'h0});
  end
endmodule

// File: tb/tb_dec_stage.sv
// tb_dec_stage: directed self-checking bench for dec_stage
module tb_dec_stage;
  logic clk = 1'b0;
  logic Reset = 1'b0;
  logic [31:0] Instr = '0;
  logic IR_LdEn = 1'b0;
  logic Flush = 1'b0;
  logic RF_B_sel = 1'b0;
  logic [1:0] ImmExt = 2'd0;
  logic RF_WrEn = 1'b0;
  logic [4:0] RF_WrAddr = '0;
  logic RF_WrData_sel = 1'b0;
  logic [31:0] ALU_out = '0;
  logic [31:0] MEM_out = '0;
  logic [31:0] IR_out, RF_A, RF_B, Immed;
  logic Valid;
  int n_cmp = 0;
  int n_err = 0;

  dec_stage dut (
    .clk(clk), .Reset(Reset), .Instr(Instr), .IR_LdEn(IR_LdEn), .Flush(Flush),
    .RF_B_sel(RF_B_sel), .ImmExt(ImmExt), .RF_WrEn(RF_WrEn), .RF_WrAddr(RF_WrAddr),
    .RF_WrData_sel(RF_WrData_sel), .ALU_out(ALU_out), .MEM_out(MEM_out),
    .IR_out(IR_out), .Valid(Valid), .RF_A(RF_A), .RF_B(RF_B), .Immed(Immed)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    RF_WrEn = 1'b1; RF_WrAddr = 5'd5; ALU_out = 32'hDEAD;
    step(); step();
    Reset = 1'b1;
    RF_WrEn = 1'b0;
    n_cmp++; if (Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", Valid); end
    n_cmp++; if (IR_out !== 32'h0) begin n_err++; $display("FAIL reset_ir: got %h exp 00000000", IR_out); end
    step();
    Instr = {6'h0, 5'd5, 5'd5, 16'h0}; IR_LdEn = 1'b1; RF_B_sel = 1'b1;
    step();
    IR_LdEn = 1'b0;
    n_cmp++; if (RF_A !== 32'h0) begin n_err++; $display("FAIL reset_r5: got %h exp 00000000", RF_A); end
    n_cmp++; if (RF_B !== 32'h0) begin n_err++; $display("FAIL reset_r5_b: got %h exp 00000000", RF_B); end
    n_cmp++; if (Valid !== 1'b1) begin n_err++; $display("FAIL reset_load_valid: got %b exp 1", Valid); end
  endtask

  task automatic test_write_read();
    RF_WrEn = 1'b1; RF_WrAddr = 5'd3; RF_WrData_sel = 1'b0; ALU_out = 32'h12345678;
    step();
    RF_WrEn = 1'b0;
    Instr = {6'h0, 5'd3, 5'd4, 5'd3, 11'h0}; IR_LdEn = 1'b1;
    step();
    IR_LdEn = 1'b0; RF_B_sel = 1'b0; #1;
    n_cmp++; if (RF_A !== 32'h12345678) begin n_err++; $display("FAIL wr_rfa: got %h exp 12345678", RF_A); end
    n_cmp++; if (RF_B !== 32'h12345678) begin n_err++; $display("FAIL wr_rfb_rd: got %h exp 12345678", RF_B); end
    RF_B_sel = 1'b1; #1;
    n_cmp++; if (RF_B !== 32'h0) begin n_err++; $display("FAIL wr_rfb_rt_empty: got %h exp 00000000", RF_B); end
    RF_WrEn = 1'b1; RF_WrAddr = 5'd4; RF_WrData_sel = 1'b1; MEM_out = 32'hA5A5A5A5; ALU_out = 32'h0;
    step();
    RF_WrEn = 1'b0; #1;
    n_cmp++; if (RF_B !== 32'hA5A5A5A5) begin n_err++; $display("FAIL wr_mem_r4: got %h exp a5a5a5a5", RF_B); end
    n_cmp++; if (RF_A !== 32'h12345678) begin n_err++; $display("FAIL wr_r3_kept: got %h exp 12345678", RF_A); end
  endtask

  task automatic test_back_to_back();
    Instr = {6'h0, 5'd10, 5'd0, 16'h0}; IR_LdEn = 1'b1;
    RF_WrEn = 1'b1; RF_WrAddr = 5'd10; RF_WrData_sel = 1'b0; ALU_out = 32'h0BADBEEF;
    step();
    IR_LdEn = 1'b0; RF_WrEn = 1'b0; #1;
    n_cmp++; if (RF_A !== 32'h0BADBEEF) begin n_err++; $display("FAIL b2b_r10: got %h exp 0badbeef", RF_A); end
    n_cmp++; if (IR_out !== {6'h0, 5'd10, 5'd0, 16'h0}) begin n_err++; $display("FAIL b2b_ir: got %h exp 01400000", IR_out); end
  endtask

  task automatic test_bypass();
    Instr = {6'h0, 5'd7, 5'd7, 16'h0}; IR_LdEn = 1'b1;
    step();
    IR_LdEn = 1'b0; RF_B_sel = 1'b1; #1;
    n_cmp++; if (RF_A !== 32'h0) begin n_err++; $display("FAIL byp_r7_pre: got %h exp 00000000", RF_A); end
    RF_WrEn = 1'b1; RF_WrAddr = 5'd7; RF_WrData_sel = 1'b1; MEM_out = 32'hCAFEF00D; ALU_out = 32'h1; #1;
    n_cmp++; if (RF_A !== 32'hCAFEF00D) begin n_err++; $display("FAIL byp_a: got %h exp cafef00d", RF_A); end
    n_cmp++; if (RF_B !== 32'hCAFEF00D) begin n_err++; $display("FAIL byp_b: got %h exp cafef00d", RF_B); end
    RF_B_sel = 1'b0; #1;
    n_cmp++; if (RF_B !== 32'h0) begin n_err++; $display("FAIL byp_b_indep: got %h exp 00000000", RF_B); end
    RF_WrEn = 1'b0;
    Instr = {6'h0, 5'd0, 5'd0, 16'h0}; IR_LdEn = 1'b1;
    step();
    IR_LdEn = 1'b0;
    RF_WrEn = 1'b1; RF_WrAddr = 5'd0; #1;
    n_cmp++; if (RF_A !== 32'h0) begin n_err++; $display("FAIL byp_r0_same: got %h exp 00000000", RF_A); end
    step();
    RF_WrEn = 1'b0; #1;
    n_cmp++; if (RF_A !== 32'h0) begin n_err++; $display("FAIL byp_r0_after: got %h exp 00000000", RF_A); end
  endtask

  task automatic test_immed();
    logic [31:0] exp_imm [4];
    exp_imm[0] = 32'h00008004; exp_imm[1] = 32'hFFFF8004;
    exp_imm[2] = 32'hFFFE0010; exp_imm[3] = 32'h80040000;
    Instr = {16'h0, 16'h8004}; IR_LdEn = 1'b1;
    step();
    IR_LdEn = 1'b0;
    for (int m = 0; m < 4; m++) begin
      ImmExt = 2'(m); #1;
      n_cmp++;
      if (Immed !== exp_imm[m]) begin n_err++; $display("FAIL imm_mode%0d: got %h exp %h", m, Immed, exp_imm[m]); end
    end
    ImmExt = 2'd0;
  endtask

  task automatic test_flush();
    Instr = 32'hFFFFFFFF; IR_LdEn = 1'b1; Flush = 1'b1;
    step();
    Flush = 1'b0;
    n_cmp++; if (IR_out !== 32'h0) begin n_err++; $display("FAIL flush_ir: got %h exp 00000000", IR_out); end
    n_cmp++; if (Valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b exp 0", Valid); end
    step();
    IR_LdEn = 1'b0; Instr = 32'h0;
    n_cmp++; if (IR_out !== 32'hFFFFFFFF) begin n_err++; $display("FAIL load_ir: got %h exp ffffffff", IR_out); end
    n_cmp++; if (Valid !== 1'b1) begin n_err++; $display("FAIL load_valid: got %b exp 1", Valid); end
    step();
    n_cmp++; if (IR_out !== 32'hFFFFFFFF) begin n_err++; $display("FAIL hold_ir: got %h exp ffffffff", IR_out); end
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    n_cmp++; if (Valid !== 1'b0) begin n_err++; $display("FAIL flush_only_valid: got %b exp 0", Valid); end
  endtask

  task automatic test_async_reset();
    RF_WrEn = 1'b1; RF_WrAddr = 5'd9; RF_WrData_sel = 1'b0; ALU_out = 32'h99999999;
    Instr = {6'h0, 5'd9, 5'd9, 16'h1234}; IR_LdEn = 1'b1; ImmExt = 2'd0;
    step();
    RF_WrEn = 1'b0; IR_LdEn = 1'b0; #1;
    n_cmp++; if (RF_A !== 32'h99999999) begin n_err++; $display("FAIL ar_r9_pre: got %h exp 99999999", RF_A); end
    #1 Reset = 1'b0;
    #1;
    n_cmp++; if (IR_out !== 32'h0) begin n_err++; $display("FAIL ar_ir: got %h exp 00000000", IR_out); end
    n_cmp++; if (Valid !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %b exp 0", Valid); end
    n_cmp++; if (Immed !== 32'h0) begin n_err++; $display("FAIL ar_immed: got %h exp 00000000", Immed); end
    #1 Reset = 1'b1;
    step();
    IR_LdEn = 1'b1;
    step();
    IR_LdEn = 1'b0; #1;
    n_cmp++; if (RF_A !== 32'h0) begin n_err++; $display("FAIL ar_r9_cleared: got %h exp 00000000", RF_A); end
    n_cmp++; if (Immed !== 32'h00001234) begin n_err++; $display("FAIL ar_reload_imm: got %h exp 00001234", Immed); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_bypass();
    test_immed();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
